// File: rtl/niosii_onchip_ram_bist.sv
// Built-in self-test initiator for the single-port on-chip RAM (Avalon-MM s1).
// It writes P(a) = seed ^ a, reads it back and compares, then repeats with ~P(a).
// Optional feature macro: RAM_BIST_ERR_LOG_EN adds first-mismatch address/data capture.
module niosii_onchip_ram_bist #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [DATA_W-1:0]   seed,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_count,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic                m_chipselect,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic                m_clken,
   input  logic [DATA_W-1:0]   m_readdata
`ifdef RAM_BIST_ERR_LOG_EN
   ,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [DATA_W-1:0]   first_err_data
`endif
);

   typedef enum logic [2:0] {
      StIdle, StWr0, StRd0, StDrn0, StWr1, StRd1, StDrn1, StFin
   } state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
   localparam logic [1:0]        DrnLast  = 2'(READ_LATENCY - 1);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [1:0]              drn_q, drn_d;
   logic [DATA_W-1:0]       seed_q, seed_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [15:0]             err_q, err_d;
   // Read-tracking pipeline: entry 0 is the newest read, the tail lines up with m_readdata.
   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_W-1:0]       exp_q [READ_LATENCY];
   logic [DATA_W-1:0]       exp_d [READ_LATENCY];
`ifdef RAM_BIST_ERR_LOG_EN
   logic [ADDR_W-1:0]       adr_q [READ_LATENCY];
   logic [ADDR_W-1:0]       adr_d [READ_LATENCY];
   logic [ADDR_W-1:0]       ferr_addr_q, ferr_addr_d;
   logic [DATA_W-1:0]       ferr_data_q, ferr_data_d;
`endif

   logic              is_wr, is_rd, inv, last_addr, mismatch;
   logic [DATA_W-1:0] pattern;

   // Sequencer, address counter, read pipeline and compare/count logic.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      drn_d    = drn_q;
      seed_d   = seed_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
      is_wr    = (state_q == StWr0) || (state_q == StWr1);
      is_rd    = (state_q == StRd0) || (state_q == StRd1);
      inv      = (state_q == StWr1) || (state_q == StRd1);
      last_addr = (addr_q == LastAddr);
      pattern  = seed_q ^ DATA_W'(addr_q);
      if (inv) pattern = ~pattern;

      vld_d[0] = is_rd;
      exp_d[0] = pattern;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         exp_d[i] = exp_q[i-1];
      end
      mismatch = vld_q[READ_LATENCY-1] && (m_readdata != exp_q[READ_LATENCY-1]);
      if (mismatch && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;

`ifdef RAM_BIST_ERR_LOG_EN
      ferr_addr_d = ferr_addr_q;
      ferr_data_d = ferr_data_q;
      adr_d[0]    = addr_q;
      for (int unsigned i = 1; i < READ_LATENCY; i++) adr_d[i] = adr_q[i-1];
      // err_q only grows within a test, so zero means this is the first mismatch.
      if (mismatch && (err_q == 16'd0)) begin
         ferr_addr_d = adr_q[READ_LATENCY-1];
         ferr_data_d = m_readdata;
      end
`endif

      unique case (state_q)
         StIdle: begin
            if (start) begin
               seed_d  = seed;
               err_d   = 16'd0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               addr_d  = '0;
               state_d = StWr0;
`ifdef RAM_BIST_ERR_LOG_EN
               ferr_addr_d = '0;
               ferr_data_d = '0;
`endif
            end
         end
         StWr0, StWr1, StRd0, StRd1: begin
            addr_d = last_addr ? '0 : addr_q + 1'b1;
            if (last_addr) begin
               unique case (state_q)
                  StWr0:   state_d = StRd0;
                  StRd0:   state_d = StDrn0;
                  StWr1:   state_d = StRd1;
                  default: state_d = StDrn1;
               endcase
            end
         end
         StDrn0, StDrn1: begin
            if (drn_q == DrnLast) begin
               drn_d   = 2'd0;
               state_d = (state_q == StDrn0) ? StWr1 : StFin;
            end else begin
               drn_d = drn_q + 2'd1;
            end
         end
         StFin: begin
            done_d  = 1'b1;
            pass_d  = (err_q == 16'd0);
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset; reset also flushes the read pipeline.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         drn_q   <= 2'd0;
         seed_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 16'd0;
         vld_q   <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) exp_q[i] <= '0;
`ifdef RAM_BIST_ERR_LOG_EN
         for (int unsigned i = 0; i < READ_LATENCY; i++) adr_q[i] <= '0;
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         drn_q   <= drn_d;
         seed_q  <= seed_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         for (int unsigned i = 0; i < READ_LATENCY; i++) exp_q[i] <= exp_d[i];
`ifdef RAM_BIST_ERR_LOG_EN
         for (int unsigned i = 0; i < READ_LATENCY; i++) adr_q[i] <= adr_d[i];
         ferr_addr_q <= ferr_addr_d;
         ferr_data_q <= ferr_data_d;
`endif
      end
   end

   // Avalon outputs decode directly from the state so reset idles the bus in the same clock.
   always_comb begin
      m_chipselect = is_wr || is_rd;
      m_write      = is_wr;
      m_address    = m_chipselect ? addr_q : '0;
      m_writedata  = is_wr ? pattern : '0;
      m_byteenable = m_chipselect ? '1 : '0;
      m_clken      = 1'b1;
      busy         = busy_q;
      done         = done_q;
      pass         = pass_q;
      err_count    = err_q;
`ifdef RAM_BIST_ERR_LOG_EN
      first_err_addr = ferr_addr_q;
      first_err_data = ferr_data_q;
`endif
   end

endmodule

// File: tb/tb_niosii_onchip_ram_bist.sv
// Directed self-checking bench for niosii_onchip_ram_bist (three instances: latency 1,
// latency 3, and a 1024-word always-zero RAM). Honours RAM_BIST_ERR_LOG_EN when defined.
module tb_niosii_onchip_ram_bist;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- instance A: DEPTH=16, READ_LATENCY=1 ----------------
   logic        start_a = 1'b0;
   logic [31:0] seed_a = '0;
   logic        busy_a, done_a, pass_a, cs_a, wr_a, clken_a;
   logic [15:0] err_a;
   logic [9:0]  addr_a;
   logic [3:0]  be_a;
   logic [31:0] wd_a, rd_a;
   logic        stuck_a = 1'b0;
   logic [31:0] mem_a [16];
`ifdef RAM_BIST_ERR_LOG_EN
   logic [9:0]  fea_a;
   logic [31:0] fed_a;
`endif

   niosii_onchip_ram_bist #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .READ_LATENCY(1)) u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .seed(seed_a), .busy(busy_a),
      .done(done_a), .pass(pass_a), .err_count(err_a), .m_address(addr_a),
      .m_byteenable(be_a), .m_chipselect(cs_a), .m_write(wr_a), .m_writedata(wd_a),
      .m_clken(clken_a), .m_readdata(rd_a)
`ifdef RAM_BIST_ERR_LOG_EN
      , .first_err_addr(fea_a), .first_err_data(fed_a)
`endif
   );

   // 1-clock RAM; the stuck fault clears bit0 of word 5 on every write.
   always @(posedge clk) begin
      if (cs_a) begin
         if (wr_a) mem_a[addr_a[3:0]] <= (stuck_a && addr_a == 10'd5) ? (wd_a & ~32'h1) : wd_a;
         else      rd_a <= mem_a[addr_a[3:0]];
      end
   end

   // ---------------- instance B: DEPTH=16, READ_LATENCY=3 ----------------
   logic        start_b = 1'b0;
   logic [31:0] seed_b = '0;
   logic        busy_b, done_b, pass_b, cs_b, wr_b, clken_b;
   logic [15:0] err_b;
   logic [9:0]  addr_b;
   logic [3:0]  be_b;
   logic [31:0] wd_b, rb0, rb1, rb2;
   logic [31:0] mem_b [16];
`ifdef RAM_BIST_ERR_LOG_EN
   logic [9:0]  fea_b;
   logic [31:0] fed_b;
`endif

   niosii_onchip_ram_bist #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .READ_LATENCY(3)) u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .seed(seed_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .err_count(err_b), .m_address(addr_b),
      .m_byteenable(be_b), .m_chipselect(cs_b), .m_write(wr_b), .m_writedata(wd_b),
      .m_clken(clken_b), .m_readdata(rb2)
`ifdef RAM_BIST_ERR_LOG_EN
      , .first_err_addr(fea_b), .first_err_data(fed_b)
`endif
   );

   always @(posedge clk) begin
      if (cs_b && wr_b) mem_b[addr_b[3:0]] <= wd_b;
      if (cs_b && !wr_b) rb0 <= mem_b[addr_b[3:0]];
      rb1 <= rb0;
      rb2 <= rb1;
   end

   // ---------------- instance C: DEPTH=1024, RAM reads back zero ----------------
   logic        start_c = 1'b0;
   logic [31:0] seed_c = '0;
   logic        busy_c, done_c, pass_c, cs_c, wr_c, clken_c;
   logic [15:0] err_c;
   logic [9:0]  addr_c;
   logic [3:0]  be_c;
   logic [31:0] wd_c;
   logic [31:0] zero_c = '0;
`ifdef RAM_BIST_ERR_LOG_EN
   logic [9:0]  fea_c;
   logic [31:0] fed_c;
`endif

   niosii_onchip_ram_bist #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .READ_LATENCY(1)) u_c (
      .clk(clk), .reset_n(reset_n), .start(start_c), .seed(seed_c), .busy(busy_c),
      .done(done_c), .pass(pass_c), .err_count(err_c), .m_address(addr_c),
      .m_byteenable(be_c), .m_chipselect(cs_c), .m_write(wr_c), .m_writedata(wd_c),
      .m_clken(clken_c), .m_readdata(zero_c)
`ifdef RAM_BIST_ERR_LOG_EN
      , .first_err_addr(fea_c), .first_err_data(fed_c)
`endif
   );

   // Counts clocks from the edge that accepts start (counted as 1) until done is seen.
   task automatic wait_done_a(output int cyc);
      cyc = 1;
      while (!done_a && cyc < 5000) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic pulse_start_a(input logic [31:0] s);
      @(negedge clk);
      seed_a = s; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   initial begin
      int cyc;
      int nd;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_pass", 32'(pass_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      check("rst_cs", 32'(cs_a), 32'd0);
      check("rst_write", 32'(wr_a), 32'd0);
      check("rst_be", 32'(be_a), 32'd0);
      check("rst_wd", wd_a, 32'd0);
      check("rst_addr", 32'(addr_a), 32'd0);
      check("rst_clken", 32'(clken_a), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // Clean run, first write cycle visible right after the accepting edge
      pulse_start_a(32'hA5A5_0000);
      check("clean_busy", 32'(busy_a), 32'd1);
      check("wr0_cs", 32'(cs_a), 32'd1);
      check("wr0_write", 32'(wr_a), 32'd1);
      check("wr0_addr", 32'(addr_a), 32'd0);
      check("wr0_wd", wd_a, 32'hA5A5_0000);
      check("wr0_be", 32'(be_a), 32'hF);
      wait_done_a(cyc);
      check("clean_latency", 32'(cyc), 32'd68);
      check("clean_pass", 32'(pass_a), 32'd1);
      check("clean_err", 32'(err_a), 32'd0);
      check("clean_word3", mem_a[3], 32'h5A5A_FFFC);
      check("clean_word0", mem_a[0], 32'h5A5A_FFFF);
      check("clean_word15", mem_a[15], 32'h5A5A_FFF0);
      check("clean_done_busy", 32'(busy_a), 32'd0);

      // Start in the done cycle is accepted; this run has the stuck bit on word 5
      stuck_a = 1'b1;
      seed_a = 32'hA5A5_0000; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      check("b2b_busy", 32'(busy_a), 32'd1);
      check("b2b_pass_cleared", 32'(pass_a), 32'd0);
      check("b2b_done_pulse", 32'(done_a), 32'd0);
      wait_done_a(cyc);
      check("stuck_latency", 32'(cyc), 32'd68);
      check("stuck_err", 32'(err_a), 32'd1);
      check("stuck_pass", 32'(pass_a), 32'd0);
`ifdef RAM_BIST_ERR_LOG_EN
      check("stuck_fe_addr", 32'(fea_a), 32'd5);
      check("stuck_fe_data", fed_a, 32'hA5A5_0004);
`endif

      // Reset mid-test during RD0 at address 7 (stuck still on, so err is 1 before reset)
      pulse_start_a(32'hA5A5_0000);
      nd = 0;
      while (!(cs_a && !wr_a && addr_a == 10'd7) && nd < 200) begin
         @(posedge clk); #1; nd++;
      end
      check("rd0_addr7_reached", 32'(addr_a), 32'd7);
      check("rd0_err_before_rst", 32'(err_a), 32'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("midrst_busy", 32'(busy_a), 32'd0);
      check("midrst_cs", 32'(cs_a), 32'd0);
      check("midrst_err", 32'(err_a), 32'd0);
      nd = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done_a) nd++;
      end
      check("midrst_no_done", 32'(nd), 32'd0);
      stuck_a = 1'b0;
      pulse_start_a(32'hA5A5_0000);
      wait_done_a(cyc);
      check("after_rst_latency", 32'(cyc), 32'd68);
      check("after_rst_pass", 32'(pass_a), 32'd1);
      check("after_rst_err", 32'(err_a), 32'd0);

      // Start while busy (in WR1) is ignored
      pulse_start_a(32'h0F0F_0000);
      repeat (38) @(posedge clk);
      #1;
      check("wr1_state_write", 32'(wr_a), 32'd1);
      pulse_start_a(32'h0000_0001);
      check("ignored_busy", 32'(busy_a), 32'd1);
      nd = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done_a) nd++;
      end
      check("ignored_one_done", 32'(nd), 32'd1);
      check("ignored_pass", 32'(pass_a), 32'd1);
      check("ignored_word3", mem_a[3], 32'hF0F0_FFFC);

      // Latency sweep, READ_LATENCY=3
      @(negedge clk);
      seed_b = 32'h1234_5678; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 5000) begin
         @(posedge clk); #1; cyc++;
      end
      check("lat3_latency", 32'(cyc), 32'd72);
      check("lat3_pass", 32'(pass_b), 32'd1);
      check("lat3_err", 32'(err_b), 32'd0);
      check("lat3_word2", mem_b[2], 32'hEDCB_A985);

      // 1024 words against an always-zero RAM: only pass-1 address 0 matches
      @(negedge clk);
      seed_c = 32'hFFFF_FFFF; start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      cyc = 1;
      while (!done_c && cyc < 10000) begin
         @(posedge clk); #1; cyc++;
      end
      check("sat_latency", 32'(cyc), 32'd4100);
      check("sat_err", 32'(err_c), 32'd2047);
      check("sat_pass", 32'(pass_c), 32'd0);
`ifdef RAM_BIST_ERR_LOG_EN
      check("sat_fe_addr", 32'(fea_c), 32'd0);
      check("sat_fe_data", fed_c, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
